// File: rtl/fpmul_share_ctrl_pkg.sv
// Shared constants and helpers for the fpmul sharing controller.
package fpmul_share_ctrl_pkg;

    localparam int FP16_W = 16;
    localparam int FPMUL_LAT = 8;
    localparam logic [4:0] EXP_ALL_ONES = 5'b11111;

    // Direction of the in-flight counter update for one edge.
    typedef enum logic [1:0] {
        INF_HOLD = 2'b00,
        INF_INC  = 2'b01,
        INF_DEC  = 2'b10
    } inf_op_e;

    // An issue and a capture on the same edge cancel out.
    function automatic inf_op_e inf_op(input logic issue, input logic capture);
        inf_op_e op;
        case ({issue, capture})
            2'b10:   op = INF_INC;
            2'b01:   op = INF_DEC;
            default: op = INF_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fpmul_rr_arb.sv
// Combinational round-robin arbiter: scans from rr_ptr upward, modulo NREQ.
module fpmul_rr_arb
    import fpmul_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_grant
);

    logic [IDW-1:0] idx_s;
    logic           hit_s;

    // First eligible requester at or after the pointer wins; later hits are masked.
    always_comb begin
        grant     = {NREQ{1'b0}};
        winner    = {IDW{1'b0}};
        any_grant = 1'b0;
        idx_s     = {IDW{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s        = IDW'((int'(rr_ptr) + i) % NREQ);
            hit_s        = !any_grant && elig[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            winner       = hit_s ? idx_s : winner;
            any_grant    = any_grant | hit_s;
        end
    end

endmodule

// File: rtl/fpmul_share_ctrl.sv
// Shares one pipelined half-precision multiplier between NREQ requesters.
// A tag pipe follows each issued operation so the result can be routed back
// to the requester that launched it.
module fpmul_share_ctrl
    import fpmul_share_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FP_W    = FP16_W,
    parameter int MUL_LAT = FPMUL_LAT,
    parameter int IDW     = 2,
    parameter int CNTW    = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_a,
    input  logic [FP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W*NREQ-1:0] rsp_out,
    output logic [NREQ-1:0]      rsp_overflow,
    output logic [NREQ-1:0]      rsp_sub,
    output logic [FP_W-1:0]      mul_a,
    output logic [FP_W-1:0]      mul_b,
    input  logic [FP_W-1:0]      mul_out,
    input  logic                 mul_overflow,
    input  logic                 mul_sub,
    output logic [CNTW-1:0]      inflight
);

    logic [NREQ-1:0]      pend_r;
    logic [NREQ-1:0]      elig_s;
    logic [NREQ-1:0]      grant_s;
    logic [IDW-1:0]       winner_s;
    logic                 any_grant_s;
    logic [IDW-1:0]       rr_ptr_r;
    logic [IDW-1:0]       rr_next_s;
    logic [MUL_LAT-1:0]   tag_vld_r;
    logic [IDW-1:0]       tag_id_r [MUL_LAT];
    logic                 cap_s;
    logic [IDW-1:0]       cap_id_s;
    logic [FP_W-1:0]      mul_a_r;
    logic [FP_W-1:0]      mul_b_r;
    logic [NREQ-1:0]      rsp_valid_r;
    logic [FP_W*NREQ-1:0] rsp_out_r;
    logic [NREQ-1:0]      rsp_ovf_r;
    logic [NREQ-1:0]      rsp_sub_r;
    logic [CNTW-1:0]      inflight_r;

    // A requester with an op in flight or an unconsumed result may not issue again.
    assign elig_s    = req_valid & ~pend_r;
    assign req_ready = grant_s;

    fpmul_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .elig      (elig_s),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .winner    (winner_s),
        .any_grant (any_grant_s)
    );

    assign rr_next_s = (winner_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : winner_s + IDW'(1);
    assign cap_s     = tag_vld_r[MUL_LAT-1];
    assign cap_id_s  = tag_id_r[MUL_LAT-1];

    assign mul_a        = mul_a_r;
    assign mul_b        = mul_b_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_out      = rsp_out_r;
    assign rsp_overflow = rsp_ovf_r;
    assign rsp_sub      = rsp_sub_r;
    assign inflight     = inflight_r;

    // Register the winner's operands into the multiplier; hold them when idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mul_a_r <= {FP_W{1'b0}};
            mul_b_r <= {FP_W{1'b0}};
        end else if (any_grant_s) begin
            mul_a_r <= req_a[FP_W*winner_s +: FP_W];
            mul_b_r <= req_b[FP_W*winner_s +: FP_W];
        end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
        end
    end

    // Advance the round-robin pointer past each winner.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr_r <= {IDW{1'b0}};
        end else if (any_grant_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipe mirrors the multiplier latency and never stalls; reset drops in-flight tags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_vld_r <= {MUL_LAT{1'b0}};
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_r[i] <= {IDW{1'b0}};
            end
        end else begin
            tag_vld_r   <= {tag_vld_r[MUL_LAT-2:0], any_grant_s};
            tag_id_r[0] <= winner_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Pending flag: set on issue, cleared when the requester takes its result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_r <= {NREQ{1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_s[i]) begin
                    pend_r[i] <= 1'b1;
                end else if (rsp_valid_r[i] && rsp_ready[i]) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
            end
        end
    end

    // Capture the multiplier output into the tagged requester's response slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid_r <= {NREQ{1'b0}};
            rsp_out_r   <= {(FP_W*NREQ){1'b0}};
            rsp_ovf_r   <= {NREQ{1'b0}};
            rsp_sub_r   <= {NREQ{1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cap_s && (cap_id_s == IDW'(i))) begin
                    rsp_valid_r[i]             <= 1'b1;
                    rsp_out_r[FP_W*i +: FP_W]  <= mul_out;
                    rsp_ovf_r[i]               <= mul_overflow;
                    rsp_sub_r[i]               <= mul_sub;
                end else if (rsp_valid_r[i] && rsp_ready[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else begin
                    rsp_valid_r[i] <= rsp_valid_r[i];
                end
            end
        end
    end

    // Count operations issued but not yet captured.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inflight_r <= {CNTW{1'b0}};
        end else begin
            case (inf_op(any_grant_s, cap_s))
                INF_INC: inflight_r <= inflight_r + CNTW'(1);
                INF_DEC: inflight_r <= inflight_r - CNTW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: directed steps plus a scoreboard of expected
// products keyed by requester id, with a delay-line multiplier model.
module tb_fpmul_share_ctrl;
    import fpmul_share_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int LAT  = 8;
    localparam int IDW  = 2;
    localparam int CNTW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W*NREQ-1:0] req_a, req_b, rsp_out;
    logic [NREQ-1:0]   rsp_overflow, rsp_sub;
    logic [W-1:0]      mul_a, mul_b, mul_out;
    logic              mul_overflow, mul_sub;
    logic [CNTW-1:0]   inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [17:0] res;
    } sb_t;
    sb_t sb_q[$];

    int grants [NREQ];
    int wait_cnt [NREQ];
    bit pb [NREQ];
    int starve_max = 0;
    int infl_max = 0;

    fpmul_share_ctrl #(
        .NREQ(NREQ), .FP_W(W), .MUL_LAT(LAT), .IDW(IDW), .CNTW(CNTW)
    ) dut (
        .CLK(clk), .RST(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_overflow(rsp_overflow), .rsp_sub(rsp_sub),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .mul_overflow(mul_overflow), .mul_sub(mul_sub),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Reference half-precision multiply (normals, truncating): {ovf, sub, out}.
    function automatic logic [17:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] p;
        logic [9:0]  m;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {2'b00, s, 15'd0};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {1'b1, 1'b0, s, EXP_ALL_ONES, 10'd0};
        if (e <= 0) return {1'b0, 1'b1, s, 15'd0};
        return {2'b00, s, e[4:0], m};
    endfunction

    // Delay-line multiplier: result for operands registered at edge k is visible before edge k+LAT.
    logic [17:0] dl [LAT-1];
    always @(posedge clk) begin
        dl[0] <= fmul(mul_a, mul_b);
        for (int j = 1; j < LAT - 1; j++) dl[j] <= dl[j-1];
    end
    assign mul_out      = dl[LAT-2][15:0];
    assign mul_sub      = dl[LAT-2][16];
    assign mul_overflow = dl[LAT-2][17];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result data may be exact or one LSB above the reference.
    task automatic chk_close(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp || obs === exp + 16'd1) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_fp();
        logic [15:0] v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(1, 30));
        v[9:0]   = 10'($urandom);
        return v;
    endfunction

    task automatic wait_rsp(input int id, input int lim, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < lim && !seen; c++) begin
            step();
            seen = rsp_valid[id];
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            done = (sb_q.size() == 0) && (inflight == 3'd0) && (rsp_valid == 4'd0);
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    bit          acc;
    int          f;
    logic [17:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            for (int i = 0; i < NREQ; i++) begin
                pb[i] = 1'b0;
                wait_cnt[i] = 0;
            end
        end else begin
            if (int'(inflight) > infl_max) infl_max = int'(inflight);
            acc = |(req_valid & req_ready);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !pb[i] && !req_ready[i] && acc) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > starve_max) starve_max = wait_cnt[i];
                end else if (req_ready[i] || !req_valid[i]) begin
                    wait_cnt[i] = 0;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    f = -1;
                    for (int k = 0; k < sb_q.size(); k++)
                        if (f < 0 && sb_q[k].id == i) f = k;
                    chk("rsp_expected", 32'(f >= 0), 32'd1);
                    if (f >= 0) begin
                        e = sb_q[f].res;
                        sb_q.delete(f);
                        chk_close("rsp_data", rsp_out[W*i +: W], e[15:0]);
                        chk("rsp_ovf", 32'(rsp_overflow[i]), 32'(e[17]));
                        chk("rsp_sub", 32'(rsp_sub[i]), 32'(e[16]));
                    end
                    pb[i] = 1'b0;
                end
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back('{id: i, res: fmul(req_a[W*i +: W], req_b[W*i +: W])});
                    grants[i]++;
                    pb[i] = 1'b1;
                end
            end
        end
    end

    int  g_base [NREQ];
    int  gmin, gmax;
    bit  seen, ok;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) step();
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out[31:0]), 32'd0);
        rst_n = 1'b1;
        step();

        // All four requesters at once.
        req_a = {16'h7BFF, 16'h3C00, 16'h3800, 16'h4200};
        req_b = {16'h7BFF, 16'h4000, 16'h3800, 16'hC000};
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int j = 0; j < NREQ; j++) begin
            #1;
            chk("arb_order", 32'(req_ready), 32'(1 << j));
            step();
            req_valid[j] = 1'b0;
        end
        chk("inflight_4", 32'(inflight), 32'd4);
        wait_rsp(3, 20, seen);
        chk("ovf3_seen", 32'(seen), 32'd1);
        chk("ovf3_flag", 32'(rsp_overflow[3]), 32'd1);
        chk("ovf3_data", 32'(rsp_out[63:48]), 32'h7C00);
        drain();
        chk("data0", 32'(rsp_out[15:0]), 32'hC600);
        chk("data1", 32'(rsp_out[31:16]), 32'h3400);
        chk("data2", 32'(rsp_out[47:32]), 32'h4000);
        chk("infl_peak", 32'(infl_max), 32'd4);

        // Single op with exact latency.
        rsp_ready = 4'h0;
        req_a[15:0] = 16'h3C00;
        req_b[15:0] = 16'h4000;
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        chk("single_mul_a", 32'(mul_a), 32'h3C00);
        chk("single_mul_b", 32'(mul_b), 32'h4000);
        chk("single_infl", 32'(inflight), 32'd1);
        repeat (LAT - 1) step();
        chk("single_early", 32'(rsp_valid), 32'd0);
        step();
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_data", 32'(rsp_out[15:0]), 32'h4000);
        chk("single_ovf", 32'(rsp_overflow[0]), 32'd0);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = 4'b0000;
        #1;
        chk("single_clear", 32'(rsp_valid), 32'd0);

        // Backpressure on requester 1.
        req_a[31:16] = 16'h3800;
        req_b[31:16] = 16'h3800;
        rsp_ready = 4'b1101;
        req_valid = 4'b0011;
        wait_rsp(1, 20, seen);
        chk("bp_seen", 32'(seen), 32'd1);
        g_base[0] = grants[0];
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            ok = ok && !req_ready[1] && rsp_valid[1] && (rsp_out[31:16] == 16'h3400);
        end
        chk("bp_hold", 32'(ok), 32'd1);
        chk("bp_others", 32'(grants[0] - g_base[0] >= 2), 32'd1);
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            seen = req_ready[1];
            if (!seen) step();
        end
        chk("bp_reaccept", 32'(seen), 32'd1);
        step();
        req_valid = 4'h0;
        rsp_ready = 4'hF;
        drain();

        // Fairness under full load.
        for (int i = 0; i < NREQ; i++) g_base[i] = grants[i];
        req_valid = 4'hF;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[W*i +: W] = rnd_fp();
                req_b[W*i +: W] = rnd_fp();
            end
            step();
        end
        req_valid = 4'h0;
        drain();
        gmin = grants[0] - g_base[0];
        gmax = gmin;
        for (int i = 1; i < NREQ; i++) begin
            if (grants[i] - g_base[i] < gmin) gmin = grants[i] - g_base[i];
            if (grants[i] - g_base[i] > gmax) gmax = grants[i] - g_base[i];
        end
        chk("fair_spread", 32'(gmax - gmin <= 1), 32'd1);
        chk("fair_busy", 32'(gmin >= 15), 32'd1);
        chk("starve", 32'(starve_max <= NREQ), 32'd1);

        // Reset while three ops are in flight.
        req_a[47:32] = 16'h4200;
        req_b[47:32] = 16'hC000;
        req_valid = 4'b0111;
        for (int j = 0; j < 3; j++) begin
            step();
            req_valid[j] = 1'b0;
        end
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_mul_a", 32'(mul_a), 32'd0);
        chk("arst_mul_b", 32'(mul_b), 32'd0);
        chk("arst_infl", 32'(inflight), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_out", 32'(rsp_out[31:0] | rsp_out[63:32]), 32'd0);
        step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            ok = ok && (rsp_valid == 4'd0);
        end
        chk("arst_no_stale", 32'(ok), 32'd1);
        req_valid = 4'b0100;
        rsp_ready = 4'b0000;
        step();
        req_valid = 4'b0000;
        wait_rsp(2, 15, seen);
        chk("arst_post_seen", 32'(seen), 32'd1);
        chk("arst_post_data", 32'(rsp_out[47:32]), 32'hC600);
        rsp_ready = 4'hF;
        drain();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 300; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_a[W*i +: W] = rnd_fp();
                req_b[W*i +: W] = rnd_fp();
            end
            step();
        end
        req_valid = 4'h0;
        rsp_ready = 4'hF;
        drain();
        chk("end_infl", 32'(inflight), 32'd0);
        chk("end_starve", 32'(starve_max <= NREQ), 32'd1);
        chk("end_infl_max", 32'(infl_max <= NREQ), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
